speed_cmd_sequencer: RTL

- Sequences the 3-bit speed code fed to bin_to_real: bit 2 = direction, bits 1:0 = magnitude 0..3.
- Arbitrates between two requesters:
  - navigation (low priority)
  - safety/bumper (high priority, preempts).
- Ramps the applied code one magnitude step at a time toward the accepted target.
- Forces a pass through magnitude 0 plus a dwell before any direction reversal, so the drive never steps directly between forward and reverse.

---
 rtl/speed_seq_pkg.sv | 33 +++
 rtl/interval_timer.sv | 41 ++++
 rtl/speed_cmd_sequencer.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/speed_seq_pkg.sv
// Shared types and helpers for the speed command sequencer.
// Speed code layout: bit 2 = direction, bits 1:0 = magnitude 0..3.
package speed_seq_pkg;

  typedef enum logic [1:0] {StIdle, StStep, StDwell} state_e;
  typedef enum logic {OwnerNav, OwnerSafe} owner_e;

  localparam int unsigned DIR_BIT = 2;
  localparam int unsigned MAG_MSB = 1;
  localparam int unsigned MAG_LSB = 0;

  // State to enter when a command with target tgt is accepted while cur is applied.
  function automatic state_e entry_state(logic [2:0] cur, logic [2:0] tgt);
    if (cur == tgt) return StIdle;
    if (cur[MAG_MSB:MAG_LSB] == 2'b00 && cur[DIR_BIT] != tgt[DIR_BIT]) return StDwell;
    return StStep;
  endfunction

  // One magnitude step: toward 0 while the direction still differs, else toward tgt.
  function automatic logic [2:0] step_code(logic [2:0] cur, logic [2:0] tgt);
    logic [1:0] mag;
    mag = cur[MAG_MSB:MAG_LSB];
    if (cur[DIR_BIT] != tgt[DIR_BIT]) begin
      if (mag != 2'b00) mag = mag - 2'd1;
    end else if (tgt[MAG_MSB:MAG_LSB] > mag) begin
      mag = mag + 2'd1;
    end else if (tgt[MAG_MSB:MAG_LSB] < mag) begin
      mag = mag - 2'd1;
    end
    return {cur[DIR_BIT], mag};
  endfunction

endpackage

// File: rtl/interval_timer.sv
// Interval counter with synchronous clear and programmable terminal value.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   en          - count enable
//   clr         - synchronous clear (wins over counting)
//   terminal    - count value at which tick fires
//   tick        - high during the cycle the count equals terminal; count wraps to 0
module interval_timer
  import speed_seq_pkg::*;
#(
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic                 clr,
  input  logic [CNT_WIDTH-1:0] terminal,
  output logic                 tick
);

  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = en && (cnt_q == terminal);
    cnt_d = cnt_q;
    if (clr || tick) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/speed_cmd_sequencer.sv
// Arbitrates navigation and safety speed commands and ramps the applied code
// one magnitude step per interval, dwelling at magnitude 0 before any reversal.
// Ports:
//   clk, reset               - clock, synchronous active-high reset
//   nav_req/nav_speed        - low-priority request (level, held until nav_ack)
//   safe_req/safe_speed      - high-priority request (level, held until safe_ack)
//   nav_ack/safe_ack         - one-cycle accept pulses
//   nav_done/safe_done       - one-cycle target-reached pulses
//   nav_abort                - one-cycle pulse when a nav command is preempted
//   busy                     - high when not idle
//   bin_speed                - registered applied speed code
module speed_cmd_sequencer
  import speed_seq_pkg::*;
#(
  parameter int unsigned RAMP_CYCLES  = 4,
  parameter int unsigned DWELL_CYCLES = 8,
  parameter int unsigned CNT_WIDTH    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       nav_req,
  input  logic [2:0] nav_speed,
  input  logic       safe_req,
  input  logic [2:0] safe_speed,
  output logic       nav_ack,
  output logic       safe_ack,
  output logic       nav_done,
  output logic       safe_done,
  output logic       nav_abort,
  output logic       busy,
  output logic [2:0] bin_speed
);

  state_e     state_q, state_d;
  owner_e     owner_q, owner_d;
  logic [2:0] target_q, target_d;
  logic [2:0] bin_speed_q, bin_speed_d;
  logic       nav_ack_q, nav_ack_d;
  logic       safe_ack_q, safe_ack_d;
  logic       nav_done_q, nav_done_d;
  logic       safe_done_q, safe_done_d;
  logic       nav_abort_q, nav_abort_d;

  logic                 tmr_en, tmr_clr, tmr_tick;
  logic [CNT_WIDTH-1:0] tmr_terminal;

  logic       acc_safe, acc_nav;
  logic [2:0] acc_speed;
  logic [2:0] next_code;

  interval_timer #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_timer (
    .clk     (clk),
    .reset   (reset),
    .en      (tmr_en),
    .clr     (tmr_clr),
    .terminal(tmr_terminal),
    .tick    (tmr_tick)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      owner_q     <= OwnerNav;
      target_q    <= 3'b000;
      bin_speed_q <= 3'b000;
      nav_ack_q   <= 1'b0;
      safe_ack_q  <= 1'b0;
      nav_done_q  <= 1'b0;
      safe_done_q <= 1'b0;
      nav_abort_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      target_q    <= target_d;
      bin_speed_q <= bin_speed_d;
      nav_ack_q   <= nav_ack_d;
      safe_ack_q  <= safe_ack_d;
      nav_done_q  <= nav_done_d;
      safe_done_q <= safe_done_d;
      nav_abort_q <= nav_abort_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    target_d    = target_q;
    bin_speed_d = bin_speed_q;
    nav_ack_d   = 1'b0;
    safe_ack_d  = 1'b0;
    nav_done_d  = 1'b0;
    safe_done_d = 1'b0;
    nav_abort_d = 1'b0;
    tmr_clr     = 1'b0;
    next_code   = bin_speed_q;

    // Safety is accepted when idle or when it can preempt a nav command;
    // nav only when idle and safety is not asking on the same edge.
    acc_safe  = safe_req && (state_q == StIdle || owner_q == OwnerNav);
    acc_nav   = nav_req && !safe_req && (state_q == StIdle);
    acc_speed = acc_safe ? safe_speed : nav_speed;

    if (acc_safe || acc_nav) begin
      target_d    = acc_speed;
      owner_d     = acc_safe ? OwnerSafe : OwnerNav;
      tmr_clr     = 1'b1;
      state_d     = entry_state(bin_speed_q, acc_speed);
      safe_ack_d  = acc_safe;
      nav_ack_d   = acc_nav;
      nav_abort_d = acc_safe && (state_q != StIdle);
      if (state_d == StIdle) begin
        safe_done_d = acc_safe;
        nav_done_d  = acc_nav;
      end
    end else if (tmr_tick) begin
      case (state_q)
        StStep:  next_code = step_code(bin_speed_q, target_q);
        StDwell: next_code = {target_q[DIR_BIT], 2'b00};
        default: next_code = bin_speed_q;
      endcase
      bin_speed_d = next_code;
      if (next_code == target_q) begin
        state_d     = StIdle;
        safe_done_d = (owner_q == OwnerSafe);
        nav_done_d  = (owner_q == OwnerNav);
      end else if (next_code[MAG_MSB:MAG_LSB] == 2'b00 &&
                   next_code[DIR_BIT] != target_q[DIR_BIT]) begin
        state_d = StDwell;
      end else begin
        state_d = StStep;
      end
    end
  end

  // Outputs
  always_comb begin
    busy         = (state_q != StIdle);
    tmr_en       = busy;
    tmr_terminal = (state_q == StDwell) ? CNT_WIDTH'(DWELL_CYCLES - 1)
                                        : CNT_WIDTH'(RAMP_CYCLES - 1);
    bin_speed    = bin_speed_q;
    nav_ack      = nav_ack_q;
    safe_ack     = safe_ack_q;
    nav_done     = nav_done_q;
    safe_done    = safe_done_q;
    nav_abort    = nav_abort_q;
  end

endmodule
